dcache_flush_unit: RTL

//  Sequences a complete write-back data-cache flush on behalf of the flush controller.
//  - Starts on flush_i, the registered flush-dcache request from the controller.
//  - Walks every set: reads the valid/dirty state, writes back each dirty way, then invalidates the set.
//  - Returns a single-cycle flush_ack_o to the controller, which then releases the fence halt.

---
 rtl/std_cache_pkg.sv | 17 +
 rtl/lzc.sv | 18 +
 rtl/dcache_flush_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/std_cache_pkg.sv
// Shared data-cache definitions: default geometry and the flush sequencer state encoding.
package std_cache_pkg;

    localparam int DCACHE_SETS = 256;
    localparam int DCACHE_WAYS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CHECK   = 3'd2,
        WB_REQ  = 3'd3,
        WB_WAIT = 3'd4,
        INVAL   = 3'd5,
        ACK     = 3'd6
    } dcache_flush_state_e;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit of i_in (0 when i_in is all zero).
module lzc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_in,
    output logic [CNT_W-1:0] o_cnt
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_cnt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_in[i]) o_cnt = CNT_W'(i);
        end
    end

endmodule

// File: rtl/dcache_flush_unit.sv
// Write-back D$ flush sequencer: per set read state, write back dirty valid ways, invalidate;
// acknowledges the controller once every set has been cleaned.
module dcache_flush_unit
    import std_cache_pkg::*;
#(
    parameter  int NR_SETS = DCACHE_SETS,
    parameter  int NR_WAYS = DCACHE_WAYS,
    localparam int IDX_W   = $clog2(NR_SETS),
    localparam int WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    output logic               flush_ack_o,
    output logic               busy_o,
    output logic               tag_req_o,
    input  logic               tag_gnt_i,
    output logic [IDX_W-1:0]   tag_set_o,
    input  logic [NR_WAYS-1:0] tag_valid_i,
    input  logic [NR_WAYS-1:0] tag_dirty_i,
    output logic               wb_req_o,
    input  logic               wb_gnt_i,
    output logic [IDX_W-1:0]   wb_set_o,
    output logic [WAY_W-1:0]   wb_way_o,
    input  logic               wb_done_i,
    output logic               inv_req_o,
    input  logic               inv_gnt_i,
    output logic [IDX_W-1:0]   inv_set_o
);

    if (NR_SETS < 2 || (NR_SETS & (NR_SETS - 1)) != 0) begin : g_bad_sets
        $error("NR_SETS must be a power of two and at least 2");
    end
    if (NR_WAYS < 1) begin : g_bad_ways
        $error("NR_WAYS must be at least 1");
    end

    dcache_flush_state_e r_state;
    logic [IDX_W-1:0]    r_set;
    logic [NR_WAYS-1:0]  r_mask;
    logic [NR_WAYS-1:0]  w_hit;
    logic [NR_WAYS-1:0]  w_mask_rem;
    logic [WAY_W-1:0]    w_way;

    // Invalid-but-dirty lines hold no live data and are skipped.
    assign w_hit      = tag_valid_i & tag_dirty_i;
    // Dropping the lowest set bit retires exactly the way that was just written back.
    assign w_mask_rem = r_mask & (r_mask - NR_WAYS'(1));

    lzc #(
        .WIDTH (NR_WAYS),
        .CNT_W (WAY_W)
    ) u_lzc (
        .i_in  (r_mask),
        .o_cnt (w_way)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_set   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_i) begin
                        r_state <= READ;
                        r_set   <= '0;
                    end
                end
                READ: begin
                    if (tag_gnt_i) r_state <= CHECK;
                end
                CHECK: begin
                    r_mask  <= w_hit;
                    r_state <= (|w_hit) ? WB_REQ : INVAL;
                end
                WB_REQ: begin
                    if (wb_gnt_i) r_state <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (wb_done_i) begin
                        r_mask  <= w_mask_rem;
                        r_state <= (|w_mask_rem) ? WB_REQ : INVAL;
                    end
                end
                INVAL: begin
                    if (inv_gnt_i) begin
                        if (r_set == IDX_W'(NR_SETS - 1)) begin
                            r_state <= ACK;
                        end else begin
                            r_set   <= r_set + IDX_W'(1);
                            r_state <= READ;
                        end
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payloads are zeroed outside their request state so idle buses stay quiet.
    assign busy_o      = (r_state != IDLE);
    assign flush_ack_o = (r_state == ACK);
    assign tag_req_o   = (r_state == READ);
    assign tag_set_o   = tag_req_o ? r_set : '0;
    assign wb_req_o    = (r_state == WB_REQ);
    assign wb_set_o    = wb_req_o ? r_set : '0;
    assign wb_way_o    = wb_req_o ? w_way : '0;
    assign inv_req_o   = (r_state == INVAL);
    assign inv_set_o   = inv_req_o ? r_set : '0;

endmodule
